// File: rtl/gfx_pkg.sv
// gfx_pkg
// Shared constants and helpers for the rasteriser fragment-colour path.
//   NUM_CH / CH_W / W_FRAC : default channel count, channel width and
//                            weight fraction bits of the colour datapath.
//   weight_t               : unsigned Q1.W_FRAC barycentric weight.
//   ch_sel(bus, i)         : extracts channel i from a packed colour bus of
//                            the default geometry.
package gfx_pkg;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 8;
    localparam int W_FRAC = 16;

    typedef logic [W_FRAC:0] weight_t;

    // Channel i lives at bits [i*CH_W +: CH_W] of every colour bus.
    function automatic logic [CH_W-1:0] ch_sel(input logic [NUM_CH*CH_W-1:0] bus,
                                               input int                      i);
        return bus[i*CH_W +: CH_W];
    endfunction

endpackage

// File: rtl/color_interp_lane.sv
// color_interp_lane
// One colour channel of the barycentric interpolator: three weighted
// products (S1), their sum (S2), then round / shift / saturate (S3).
// Holds no valid state; the parent decides when each stage may load.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en_i[2:0]         : load enables for S1, S2, S3 respectively
//   col_a_i..col_c_i  : vertex channel values
//   w_a_i..w_c_i      : Q1.W_FRAC weights
//   col_o             : registered interpolated channel
//   sat_o             : registered flag, channel was clamped
module color_interp_lane #(
    parameter int CH_W   = gfx_pkg::CH_W,
    parameter int W_FRAC = gfx_pkg::W_FRAC,
    parameter int ROUND  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        en_i,
    input  logic [CH_W-1:0]   col_a_i,
    input  logic [CH_W-1:0]   col_b_i,
    input  logic [CH_W-1:0]   col_c_i,
    input  logic [W_FRAC:0]   w_a_i,
    input  logic [W_FRAC:0]   w_b_i,
    input  logic [W_FRAC:0]   w_c_i,
    output logic [CH_W-1:0]   col_o,
    output logic              sat_o
);

    import gfx_pkg::*;

    // Product width holds CH_W x (W_FRAC+1) exactly; the sum gets two
    // guard bits so three maximal products never wrap; the rounding add
    // gets one more so a rounding carry on the largest sum is kept too.
    localparam int PW = CH_W + W_FRAC + 1;
    localparam int SW = CH_W + W_FRAC + 3;
    localparam int RW = SW + 1;

    localparam logic [RW-1:0] RND_ADD = (ROUND != 0) ? (RW'(1) << (W_FRAC - 1)) : '0;
    localparam logic [RW-1:0] CH_MAX  = RW'((1 << CH_W) - 1);

    logic [PW-1:0]   prod_a_d, prod_b_d, prod_c_d;
    logic [PW-1:0]   prod_a_q, prod_b_q, prod_c_q;
    logic [SW-1:0]   sum_d, sum_q;
    logic [RW-1:0]   rounded, shifted;
    logic [CH_W-1:0] col_d, col_q;
    logic            sat_d, sat_q;

    // Zero-extend both operands to the product width before multiplying.
    always_comb begin
        prod_a_d = {{(PW-CH_W){1'b0}}, col_a_i} * {{(PW-W_FRAC-1){1'b0}}, w_a_i};
        prod_b_d = {{(PW-CH_W){1'b0}}, col_b_i} * {{(PW-W_FRAC-1){1'b0}}, w_b_i};
        prod_c_d = {{(PW-CH_W){1'b0}}, col_c_i} * {{(PW-W_FRAC-1){1'b0}}, w_c_i};
        sum_d    = {2'b00, prod_a_q} + {2'b00, prod_b_q} + {2'b00, prod_c_q};
    end

    // Anything that does not fit in CH_W bits after the shift means the
    // weights summed above 1.0, so the channel is clamped to full scale.
    always_comb begin
        rounded = {1'b0, sum_q} + RND_ADD;
        shifted = rounded >> W_FRAC;
        sat_d   = (shifted > CH_MAX);
        col_d   = sat_d ? {CH_W{1'b1}} : shifted[CH_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_a_q <= '0;
            prod_b_q <= '0;
            prod_c_q <= '0;
            sum_q    <= '0;
            col_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            if (en_i[0]) begin
                prod_a_q <= prod_a_d;
                prod_b_q <= prod_b_d;
                prod_c_q <= prod_c_d;
            end
            if (en_i[1]) begin
                sum_q <= sum_d;
            end
            if (en_i[2]) begin
                col_q <= col_d;
                sat_q <= sat_d;
            end
        end
    end

    assign col_o = col_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/color_interp_pipe.sv
// color_interp_pipe
// Three-stage pipelined barycentric colour interpolator with valid/ready
// handshakes on both sides and a tag carried alongside each fragment.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid / in_ready       : upstream handshake
//   in_col_a/b/c              : packed vertex colours (NUM_CH x CH_W)
//   in_w_a/b/c                : Q1.W_FRAC weights
//   in_tag                    : sideband tag, passed through unchanged
//   out_valid / out_ready     : downstream handshake
//   out_col                   : interpolated colour
//   out_tag                   : tag of the fragment on out_col
//   out_sat                   : some channel of this result was clamped
module color_interp_pipe #(
    parameter int NUM_CH = gfx_pkg::NUM_CH,
    parameter int CH_W   = gfx_pkg::CH_W,
    parameter int W_FRAC = gfx_pkg::W_FRAC,
    parameter int ROUND  = 1,
    parameter int TAG_W  = 22
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CH*CH_W-1:0] in_col_a,
    input  logic [NUM_CH*CH_W-1:0] in_col_b,
    input  logic [NUM_CH*CH_W-1:0] in_col_c,
    input  logic [W_FRAC:0]        in_w_a,
    input  logic [W_FRAC:0]        in_w_b,
    input  logic [W_FRAC:0]        in_w_c,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_CH*CH_W-1:0] out_col,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_sat
);

    import gfx_pkg::*;

    logic             advance;
    logic             v1_q, v2_q, v3_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [2:0]       stage_en;
    logic [NUM_CH-1:0] lane_sat;

    // The whole pipe moves in lockstep: it only freezes when the output
    // register holds a result the consumer has not taken yet.
    assign advance  = !v3_q || out_ready;
    assign in_ready = advance;

    // A datapath stage loads only when its upstream holds a real
    // fragment, so bubbles leave the data registers untouched.
    assign stage_en = {advance && v2_q, advance && v1_q, advance && in_valid};

    // Valid bits always shift on advance so bubbles are carried, not
    // collapsed; the tag rides in step with the datapath enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            if (advance) begin
                v1_q <= in_valid;
                v2_q <= v1_q;
                v3_q <= v2_q;
            end
            if (stage_en[0]) tag1_q <= in_tag;
            if (stage_en[1]) tag2_q <= tag1_q;
            if (stage_en[2]) tag3_q <= tag2_q;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        color_interp_lane #(
            .CH_W   (CH_W),
            .W_FRAC (W_FRAC),
            .ROUND  (ROUND)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (stage_en),
            .col_a_i (in_col_a[g*CH_W +: CH_W]),
            .col_b_i (in_col_b[g*CH_W +: CH_W]),
            .col_c_i (in_col_c[g*CH_W +: CH_W]),
            .w_a_i   (in_w_a),
            .w_b_i   (in_w_b),
            .w_c_i   (in_w_c),
            .col_o   (out_col[g*CH_W +: CH_W]),
            .sat_o   (lane_sat[g])
        );
    end

    assign out_valid = v3_q;
    assign out_tag   = tag3_q;
    assign out_sat   = |lane_sat;

endmodule

// File: tb/tb_color_interp_pipe.sv
// tb_color_interp_pipe
// Scoreboard bench: two instances (round-half-up and truncate) share the
// same stimulus; each accepted fragment pushes its expected result into a
// per-instance queue and a monitor pops and compares on every transfer.
module tb_color_interp_pipe;

    import gfx_pkg::*;

    typedef struct {
        logic [23:0] col;
        logic        sat;
        logic [21:0] tag;
        int          accCyc;
        bit          chkLat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] colA, colB, colC;
    logic [16:0] wA, wB, wC;
    logic [21:0] tagIn;
    logic        out_ready;
    logic        in_readyR, out_validR, out_satR;
    logic        in_readyT, out_validT, out_satT;
    logic [23:0] out_colR, out_colT;
    logic [21:0] out_tagR, out_tagT;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   readyMode = 0;
    int   phase    = 0;
    exp_t qR[$];
    exp_t qT[$];

    bit          prevStall = 1'b0;
    logic [23:0] hCol;
    logic [21:0] hTag;
    logic        hSat;

    color_interp_pipe #(.ROUND(1), .TAG_W(22)) dutR (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_readyR),
        .in_col_a(colA), .in_col_b(colB), .in_col_c(colC),
        .in_w_a(wA), .in_w_b(wB), .in_w_c(wC), .in_tag(tagIn),
        .out_valid(out_validR), .out_ready(out_ready),
        .out_col(out_colR), .out_tag(out_tagR), .out_sat(out_satR)
    );

    color_interp_pipe #(.ROUND(0), .TAG_W(22)) dutT (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_readyT),
        .in_col_a(colA), .in_col_b(colB), .in_col_c(colC),
        .in_w_a(wA), .in_w_b(wB), .in_w_c(wC), .in_tag(tagIn),
        .out_valid(out_validT), .out_ready(out_ready),
        .out_col(out_colT), .out_tag(out_tagT), .out_sat(out_satT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: begin out_ready = (phase % 3 == 0); phase++; end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference: weighted sum, optional half-LSB add, shift, clamp.
    function automatic void modelCol(input logic [23:0] a, b, c,
                                     input weight_t wa, wb, wc, input bit rnd,
                                     output logic [23:0] col, output logic sat);
        col = '0;
        sat = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            longint s;
            s = longint'(ch_sel(a, i)) * longint'(wa) + longint'(ch_sel(b, i)) * longint'(wb)
              + longint'(ch_sel(c, i)) * longint'(wc);
            if (rnd) s = s + (longint'(1) << (W_FRAC - 1));
            s = s >>> W_FRAC;
            if (s > 255) begin
                s   = 255;
                sat = 1'b1;
            end
            col[i*CH_W +: CH_W] = s[7:0];
        end
    endfunction

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e, input logic [23:0] col,
                               input logic sat, input logic [21:0] tag);
        checks++;
        if (col !== e.col || sat !== e.sat || tag !== e.tag) begin
            failures++;
            $display("[TB] FAIL %s_result actual col=%h sat=%b tag=%h required col=%h sat=%b tag=%h",
                     name, col, sat, tag, e.col, e.sat, e.tag);
        end
        if (e.chkLat) begin
            checks++;
            if (cyc != e.accCyc + 3) begin
                failures++;
                $display("[TB] FAIL %s_latency actual=%0d required=%0d", name, cyc - e.accCyc, 3);
            end
        end
    endtask

    // Drives one fragment and holds it until accepted. Expected values are
    // either hand-supplied or taken from the reference model.
    task automatic applyStimulus(input logic [23:0] a, b, c, input logic [16:0] wa, wb, wc,
                                 input logic [21:0] tag, input bit useModel, input bit chkLat,
                                 input logic [23:0] expR, input logic satR,
                                 input logic [23:0] expT, input logic satT);
        exp_t eR, eT;
        bit   accepted = 1'b0;
        if (useModel) begin
            modelCol(a, b, c, wa, wb, wc, 1'b1, expR, satR);
            modelCol(a, b, c, wa, wb, wc, 1'b0, expT, satT);
        end
        colA = a; colB = b; colC = c;
        wA = wa; wB = wb; wC = wc;
        tagIn = tag;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !accepted; n++) begin
            @(negedge clk);
            if (in_readyR) begin
                eR = '{col: expR, sat: satR, tag: tag, accCyc: cyc, chkLat: chkLat};
                eT = '{col: expT, sat: satT, tag: tag, accCyc: cyc, chkLat: chkLat};
                qR.push_back(eR);
                qT.push_back(eT);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted tag=%h", tag);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((qR.size() != 0 || qT.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (qR.size() != 0 || qT.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0 pending", qR.size() + qT.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every transfer, checks hold stability under stall
    // and that in_ready mirrors out_ready while a result is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prevStall) begin
                checks++;
                if (!(out_validR && out_colR === hCol && out_tagR === hTag && out_satR === hSat)) begin
                    failures++;
                    $display("[TB] FAIL stall_hold actual v=%b col=%h tag=%h required v=1 col=%h tag=%h",
                             out_validR, out_colR, out_tagR, hCol, hTag);
                end
            end
            prevStall = out_validR && !out_ready;
            hCol = out_colR; hTag = out_tagR; hSat = out_satR;
            if (out_validR) checkEq("in_ready_vs_out_ready", 64'(in_readyR), 64'(out_ready));
            if (out_validR && out_ready) begin
                if (qR.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL R_unexpected actual tag=%h required=no_output", out_tagR);
                end else begin
                    e = qR.pop_front();
                    checkOutput("R", e, out_colR, out_satR, out_tagR);
                end
            end
            if (out_validT && out_ready) begin
                if (qT.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL T_unexpected actual tag=%h required=no_output", out_tagT);
                end else begin
                    e = qT.pop_front();
                    checkOutput("T", e, out_colT, out_satT, out_tagT);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] ra, rb, rc;
        logic [16:0] rwa, rwb, rwc;
        rst_n = 1'b0;
        in_valid = 1'b0;
        colA = '0; colB = '0; colC = '0;
        wA = '0; wB = '0; wC = '0;
        tagIn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("reset_out_valid", 64'(out_validR), 64'd0);
        checkEq("reset_out_col",   64'(out_colR),   64'd0);
        checkEq("reset_out_tag",   64'(out_tagR),   64'd0);
        checkEq("reset_out_sat",   64'(out_satR),   64'd0);
        checkEq("reset_in_ready",  64'(in_readyR),  64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        applyStimulus(24'h0000FF, 24'h00FF00, 24'hFF0000, 17'h10000, 17'h0, 17'h0, 22'h000001,
                      0, 1, 24'h0000FF, 0, 24'h0000FF, 0);
        applyStimulus(24'h0000FF, 24'h00FF00, 24'hFF0000, 17'h05555, 17'h05555, 17'h05556, 22'h000002,
                      0, 1, 24'h555555, 0, 24'h555454, 0);
        applyStimulus(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 17'h10000, 17'h10000, 17'h10000, 22'h000003,
                      0, 1, 24'hFFFFFF, 1, 24'hFFFFFF, 1);
        applyStimulus(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 22'h000004,
                      0, 1, 24'hFFFFFF, 1, 24'hFFFFFF, 1);
        applyStimulus(24'h123456, 24'h789ABC, 24'hDEF012, 17'h0, 17'h0, 17'h0, 22'h000005,
                      0, 1, 24'h000000, 0, 24'h000000, 0);
        applyStimulus(24'h123456, 24'h789ABC, 24'hDEF012, 17'h0, 17'h10000, 17'h0, 22'h000006,
                      0, 1, 24'h789ABC, 0, 24'h789ABC, 0);
        applyStimulus(24'h123456, 24'h789ABC, 24'hDEF012, 17'h0, 17'h0, 17'h10000, 22'h000007,
                      0, 1, 24'hDEF012, 0, 24'hDEF012, 0);
        applyStimulus(24'h0301FF, 24'h000000, 24'h000000, 17'h08000, 17'h0, 17'h0, 22'h000008,
                      0, 1, 24'h020180, 0, 24'h01007F, 0);
        applyStimulus(24'h0000FF, 24'h000080, 24'h000000, 17'h10000, 17'h10000, 17'h0, 22'h000009,
                      0, 1, 24'h0000FF, 1, 24'h0000FF, 1);
        drain();

        $display("[TB] stalled stream");
        readyMode = 1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(24'($urandom), 24'($urandom), 24'($urandom), 17'h04000, 17'h08000, 17'h04000,
                          22'(100 + i), 1, 0, '0, 0, '0, 0);
        end
        drain();

        $display("[TB] reset flush");
        readyMode = 0;
        applyStimulus(24'h0000FF, 24'h00FF00, 24'hFF0000, 17'h10000, 17'h0, 17'h0, 22'h0000A1,
                      0, 0, 24'h0000FF, 0, 24'h0000FF, 0);
        applyStimulus(24'h0000FF, 24'h00FF00, 24'hFF0000, 17'h0, 17'h10000, 17'h0, 22'h0000A2,
                      0, 0, 24'h00FF00, 0, 24'h00FF00, 0);
        rst_n = 1'b0;
        qR.delete();
        qT.delete();
        @(negedge clk);
        checkEq("flush_out_valid", 64'(out_validR), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkEq("flush_no_stale", 64'({out_validR, out_validT}), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(24'h0000FF, 24'h00FF00, 24'hFF0000, 17'h0, 17'h0, 17'h10000, 22'h0000A3,
                      0, 1, 24'hFF0000, 0, 24'hFF0000, 0);
        drain();

        $display("[TB] random regression");
        readyMode = 2;
        for (int i = 0; i < 10000; i++) begin
            ra = 24'($urandom); rb = 24'($urandom); rc = 24'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rwa = 17'($urandom); rwb = 17'($urandom); rwc = 17'($urandom);
            end else begin
                rwa = 17'($urandom_range(0, 32'h10000));
                rwb = 17'($urandom_range(0, 32'h10000 - 32'(rwa)));
                rwc = 17'h10000 - rwa - rwb;
            end
            applyStimulus(ra, rb, rc, rwa, rwb, rwc, 22'($urandom), 1, 0, '0, 0, '0, 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
